// File: rtl/enum_result_collector.sv
// enum_result_collector: captures {A, B, XOUT} from the enum-op unit, tags each
// transaction by op, keeps saturating per-op counters and buffers tagged results
// in a first-word-fall-through FIFO with a flush/drain FSM.
// Optional result checker: define ENUM_RESULT_CHECK_EN to enable ERR.
module enum_result_collector #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] XOUT,
  input  logic              FLUSH,
  output logic              FLUSH_DONE,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [1:0]        OUT_TAG,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CNT_W-1:0]  CNT_INC,
  output logic [CNT_W-1:0]  CNT_ADD,
  output logic [CNT_W-1:0]  CNT_SUB,
  output logic [CNT_W-1:0]  CNT_MUL,
  output logic              ERR
);

  localparam int AW = $clog2(DEPTH);
  // DEPTH is a power of two, so "full" is just the MSB of the count set.
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {OP_INC = 2'd0, OP_ADD = 2'd1, OP_SUB = 2'd2, OP_MUL = 2'd3} op_t;
  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       head_q, tail_q;
  logic [AW:0]         count_q;
  logic [DATA_W+1:0]   mem [DEPTH];
  logic [CNT_W-1:0]    cnt_q [4];
  op_t                 tag;
  logic                accept, pop;

  assign accept = IN_VALID && IN_READY;
  assign pop    = OUT_VALID && OUT_READY;

  // Classify the op from operand A.
  always_comb begin
    tag = OP_MUL;
    if (A == DATA_W'(17))      tag = OP_INC;
    else if (A == DATA_W'(18)) tag = OP_ADD;
    else if (A == DATA_W'(19)) tag = OP_SUB;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (accept) tail_q <= tail_q + 1'b1;
      if (pop)    head_q <= head_q + 1'b1;
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage write; contents are qualified by OUT_VALID so no reset.
  always_ff @(posedge CLK) begin
    if (accept) mem[tail_q] <= {tag, XOUT};
  end

  assign OUT_VALID = (count_q != '0);
  assign OUT_TAG   = mem[head_q][DATA_W +: 2];
  assign OUT_DATA  = mem[head_q][DATA_W-1:0];

  // Saturating per-op transaction counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (accept && (cnt_q[tag] != '1)) begin
      cnt_q[tag] <= cnt_q[tag] + 1'b1;
    end
  end

  assign CNT_INC = cnt_q[0];
  assign CNT_ADD = cnt_q[1];
  assign CNT_SUB = cnt_q[2];
  assign CNT_MUL = cnt_q[3];

  // Flush FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Flush FSM next-state: FLUSH while draining is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (FLUSH) state_d = ST_DRAIN;
      ST_DRAIN: if (count_q == '0) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Flush FSM outputs: input gating and the drain-complete pulse.
  always_comb begin
    IN_READY   = !RST && (state_q == ST_RUN) && (count_q != FULL);
    FLUSH_DONE = (state_q == ST_DRAIN) && (count_q == '0);
  end

`ifdef ENUM_RESULT_CHECK_EN
  logic [DATA_W-1:0] expected;
  logic              err_q;

  // Recompute the enum-op result, modulo 2**DATA_W.
  always_comb begin
    case (tag)
      OP_INC:  expected = A + DATA_W'(1);
      OP_ADD:  expected = A + B;
      OP_SUB:  expected = A - B;
      default: expected = A * B;
    endcase
  end

  // Sticky mismatch flag, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST)                             err_q <= 1'b0;
    else if (accept && XOUT != expected) err_q <= 1'b1;
  end

  assign ERR = err_q;
`else
  logic unused_b;
  assign unused_b = ^B;
  assign ERR      = 1'b0;
`endif

endmodule

// File: tb/tb_enum_result_collector.sv
// Bench for enum_result_collector: scoreboard queue filled by the stimulus,
// drained and compared by an independent output monitor.
module tb_enum_result_collector;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [7:0]  A = '0, B = '0, XOUT = '0;
  logic        FLUSH = 1'b0;
  logic        FLUSH_DONE;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [1:0]  OUT_TAG;
  logic [7:0]  OUT_DATA;
  logic [15:0] CNT_INC, CNT_ADD, CNT_SUB, CNT_MUL;
  logic        ERR;

  int pass_cnt = 0;
  int total_cnt = 0;
  int last_wait = 0;
  logic [9:0] exp_q[$];

  enum_result_collector #(.DATA_W(8), .DEPTH(4), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .XOUT(XOUT), .FLUSH(FLUSH), .FLUSH_DONE(FLUSH_DONE),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_TAG(OUT_TAG),
    .OUT_DATA(OUT_DATA), .CNT_INC(CNT_INC), .CNT_ADD(CNT_ADD),
    .CNT_SUB(CNT_SUB), .CNT_MUL(CNT_MUL), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  // Output monitor: every head that is popped must match the scoreboard front.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge CLK);
      if (!RST && OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) check("sb_unexpected_output", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("sb_tag", {30'd0, OUT_TAG}, {30'd0, e[9:8]});
          check("sb_data", {24'd0, OUT_DATA}, {24'd0, e[7:0]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Offer one transaction; push its expected {tag,result} when it is accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] x,
                      input logic [1:0] t);
    int w = 0;
    A = a; B = b; XOUT = x; IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && w < 50) begin
      @(negedge CLK);
      w++;
    end
    last_wait = w;
    if (!IN_READY) check("send_timeout", 0, 1);
    else exp_q.push_back({t, x});
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int w = 0;
    @(negedge CLK);
    while (OUT_VALID && w < 50) begin
      @(negedge CLK);
      w++;
    end
    check(nm, {31'd0, OUT_VALID}, 0);
    check({nm, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("ready_in_reset", {31'd0, IN_READY}, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_q.delete();
  endtask

  logic [7:0] va [10] = '{8'd17, 8'd18, 8'd19, 8'd20, 8'd0, 8'd255, 8'd17, 8'd100, 8'd19, 8'd7};
  logic [7:0] vb [10] = '{8'd0, 8'd200, 8'd25, 8'd13, 8'd9, 8'd2, 8'd77, 8'd3, 8'd19, 8'd6};
  logic [7:0] vx [10] = '{8'd18, 8'd218, 8'd250, 8'd4, 8'd0, 8'd254, 8'd18, 8'd44, 8'd0, 8'd42};
  logic [1:0] vt [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd2, 2'd3};

  initial begin
    int cyc, last_pop, done_cyc;

    // 1. Reset
    do_reset();
    @(negedge CLK);
    check("rst_in_ready", {31'd0, IN_READY}, 1);
    check("rst_out_valid", {31'd0, OUT_VALID}, 0);
    check("rst_flush_done", {31'd0, FLUSH_DONE}, 0);
    check("rst_cnt_inc", {16'd0, CNT_INC}, 0);
    check("rst_cnt_add", {16'd0, CNT_ADD}, 0);
    check("rst_cnt_sub", {16'd0, CNT_SUB}, 0);
    check("rst_cnt_mul", {16'd0, CNT_MUL}, 0);
    check("rst_err", {31'd0, ERR}, 0);
    @(posedge CLK); #1;

    // 2. Single op
    send(8'd17, 8'd5, 8'd18, 2'd0);
    OUT_READY = 1'b1;
    @(negedge CLK);
    check("single_out_valid", {31'd0, OUT_VALID}, 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("single_popped", {31'd0, OUT_VALID}, 0);
    check("single_cnt_inc", {16'd0, CNT_INC}, 1);
    @(posedge CLK); #1;
    OUT_READY = 1'b0;

    // 3. Fill and backpressure
    send(8'd18, 8'd3, 8'd21, 2'd1);
    send(8'd19, 8'd3, 8'd16, 2'd2);
    send(8'd20, 8'd3, 8'd60, 2'd3);
    send(8'd18, 8'd1, 8'd19, 2'd1);
    A = 8'd17; B = 8'd1; XOUT = 8'd18; IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("full_in_ready", {31'd0, IN_READY}, 0);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    check("full_cnt_inc_unchanged", {16'd0, CNT_INC}, 1);
    OUT_READY = 1'b1;
    wait_empty("fill_drain");
    check("fill_cnt_add", {16'd0, CNT_ADD}, 2);
    check("fill_cnt_sub", {16'd0, CNT_SUB}, 1);
    check("fill_cnt_mul", {16'd0, CNT_MUL}, 1);
    @(posedge CLK); #1;

    // 4. Wrap with simultaneous push/pop
    for (int i = 0; i < 10; i++) begin
      send(va[i], vb[i], vx[i], vt[i]);
      check("b2b_no_stall", last_wait, 0);
    end
    wait_empty("b2b_drain");
    check("b2b_cnt_inc", {16'd0, CNT_INC}, 3);
    check("b2b_cnt_add", {16'd0, CNT_ADD}, 3);
    check("b2b_cnt_sub", {16'd0, CNT_SUB}, 3);
    check("b2b_cnt_mul", {16'd0, CNT_MUL}, 6);
    @(posedge CLK); #1;

    // 5. Flush with 3 entries queued
    OUT_READY = 1'b0;
    send(8'd18, 8'd2, 8'd20, 2'd1);
    send(8'd19, 8'd9, 8'd10, 2'd2);
    send(8'd17, 8'd1, 8'd18, 2'd0);
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    A = 8'd17; B = 8'd0; XOUT = 8'd18; IN_VALID = 1'b1;
    @(negedge CLK);
    check("drain_in_ready", {31'd0, IN_READY}, 0);
    check("drain_no_done_yet", {31'd0, FLUSH_DONE}, 0);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    cyc = 0; last_pop = -10; done_cyc = -1;
    while (cyc < 20 && done_cyc < 0) begin
      @(negedge CLK);
      if (FLUSH_DONE) done_cyc = cyc;
      else begin
        check("drain_gated", {31'd0, IN_READY}, 0);
        if (OUT_VALID) last_pop = cyc;
      end
      cyc++;
    end
    check("flush_done_seen", done_cyc >= 0, 1);
    check("flush_done_timing", done_cyc, last_pop + 1);
    check("flush_done_ready", {31'd0, IN_READY}, 0);
    @(negedge CLK);
    check("flush_done_pulse_1cyc", {31'd0, FLUSH_DONE}, 0);
    check("flush_ready_after", {31'd0, IN_READY}, 1);
    check("flush_sb_empty", exp_q.size(), 0);
    check("flush_cnt_inc", {16'd0, CNT_INC}, 4);
    @(posedge CLK); #1;

    // Flush with an empty FIFO
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    @(negedge CLK);
    check("eflush_done", {31'd0, FLUSH_DONE}, 1);
    check("eflush_ready", {31'd0, IN_READY}, 0);
    @(negedge CLK);
    check("eflush_done_clear", {31'd0, FLUSH_DONE}, 0);
    check("eflush_ready_back", {31'd0, IN_READY}, 1);
    @(posedge CLK); #1;

    // 6. Result checker
    send(8'd19, 8'd20, 8'hFF, 2'd2);
    @(negedge CLK);
    check("chk_good_sub_err", {31'd0, ERR}, 0);
    @(posedge CLK); #1;
    send(8'd20, 8'd20, 8'h00, 2'd3);
    @(negedge CLK);
`ifdef ENUM_RESULT_CHECK_EN
    check("chk_bad_mul_err", {31'd0, ERR}, 1);
`else
    check("chk_disabled_err", {31'd0, ERR}, 0);
`endif
    @(posedge CLK); #1;
    send(8'd17, 8'd0, 8'd18, 2'd0);
    wait_empty("chk_drain");
`ifdef ENUM_RESULT_CHECK_EN
    check("chk_err_sticky", {31'd0, ERR}, 1);
`else
    check("chk_err_tied", {31'd0, ERR}, 0);
`endif
    check("chk_cnt_mul", {16'd0, CNT_MUL}, 7);
    @(posedge CLK); #1;

    // Reset mid-operation discards contents, counters and ERR
    OUT_READY = 1'b0;
    send(8'd20, 8'd20, 8'h00, 2'd3);
    send(8'd18, 8'd1, 8'd19, 2'd1);
    do_reset();
    @(negedge CLK);
    check("rst2_out_valid", {31'd0, OUT_VALID}, 0);
    check("rst2_in_ready", {31'd0, IN_READY}, 1);
    check("rst2_err", {31'd0, ERR}, 0);
    check("rst2_cnt_mul", {16'd0, CNT_MUL}, 0);
    check("rst2_cnt_add", {16'd0, CNT_ADD}, 0);
    @(posedge CLK); #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
